bcci_frame_ctrl: RTL and testbench

AXI4-Lite-programmable frame sequencer for the bicubic upsampling core.
- Holds control/status registers and gates the datapath enable.
- Monitors the upsampled output AXI-Stream handshake, counting beats and lines.
- Raises interrupt_updone when a full destination frame has left the core.
- Sits between the host AXI-Lite port and the upsampling datapath inside the IP top.

---
 rtl/bcci_frame_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_bcci_frame_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bcci_frame_ctrl.sv
// rtl/bcci_frame_ctrl.sv - AXI-Lite frame sequencer for the bicubic upsampling core
// Holds CTRL/STATUS/LINE_CNT/FRAME_CNT, gates the datapath and counts output beats per frame.
module bcci_frame_ctrl #(
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int DST_IMG_WIDTH  = 3840,
   parameter int DST_IMG_HEIGHT = 2160,
   parameter int PIX_PER_BEAT   = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          s_axi_awvalid,
   output logic                          s_axi_awready,
   input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
   input  logic                          s_axi_wvalid,
   output logic                          s_axi_wready,
   input  logic [AXI_DATA_WIDTH-1:0]     s_axi_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
   output logic                          s_axi_bvalid,
   input  logic                          s_axi_bready,
   output logic [1:0]                    s_axi_bresp,
   input  logic                          s_axi_arvalid,
   output logic                          s_axi_arready,
   input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
   output logic                          s_axi_rvalid,
   input  logic                          s_axi_rready,
   output logic [AXI_DATA_WIDTH-1:0]     s_axi_rdata,
   output logic [1:0]                    s_axi_rresp,
   input  logic                          mon_tvalid,
   input  logic                          mon_tready,
   input  logic                          mon_tlast,
   output logic                          upsp_en,
   output logic                          upsp_clr,
   output logic                          interrupt_updone
);

   localparam int          BEATS_PER_LINE = DST_IMG_WIDTH / PIX_PER_BEAT;
   localparam logic [31:0] LAST_BEAT      = 32'(BEATS_PER_LINE - 1);
   localparam logic [31:0] LAST_LINE      = 32'(DST_IMG_HEIGHT - 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t state_q, state_d;

   logic                      awready_q, awready_d, wready_q, wready_d;
   logic                      aw_full_q, aw_full_d, w_full_q, w_full_d;
   logic [1:0]                waddr_q, waddr_d;
   logic [2:0]                wdata_q, wdata_d;
   logic                      wstrb0_q, wstrb0_d;
   logic                      bvalid_q, bvalid_d;
   logic                      arready_q, arready_d, rvalid_q, rvalid_d;
   logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [31:0]               beat_cnt_q, beat_cnt_d, line_cnt_q, line_cnt_d;
   logic [31:0]               frame_cnt_q, frame_cnt_d;
   logic                      irq_en_q, irq_en_d, done_q, done_d, err_q, err_d;
   logic                      irq_q, irq_d;

   logic wr_fire, wr_en, ctrl_wr, status_wr, start_req, abort_req;
   logic hs, beat_last, line_last, frame_end, clr_pulse;

   logic unused_bits;
   assign unused_bits = ^{s_axi_awaddr[AXI_ADDR_WIDTH-1:4], s_axi_awaddr[1:0],
                          s_axi_araddr[AXI_ADDR_WIDTH-1:4], s_axi_araddr[1:0],
                          s_axi_wdata[AXI_DATA_WIDTH-1:3], s_axi_wstrb[AXI_DATA_WIDTH/8-1:1]};

   // Register writes take effect on the same edge that raises bvalid.
   assign wr_fire   = aw_full_q && w_full_q && !bvalid_q;
   assign wr_en     = wr_fire && wstrb0_q;
   assign ctrl_wr   = wr_en && (waddr_q == 2'd0);
   assign status_wr = wr_en && (waddr_q == 2'd1);
   assign start_req = ctrl_wr && wdata_q[0];
   assign abort_req = ctrl_wr && wdata_q[2];

   assign hs        = mon_tvalid && mon_tready;
   assign beat_last = (beat_cnt_q == LAST_BEAT);
   assign line_last = (line_cnt_q == LAST_LINE);
   assign frame_end = (state_q == RUN) && hs && beat_last && line_last;

   always_comb begin
      awready_d = s_axi_awvalid && !aw_full_q && !bvalid_q && !awready_q;
      wready_d  = s_axi_wvalid && !w_full_q && !bvalid_q && !wready_q;
      aw_full_d = aw_full_q;
      w_full_d  = w_full_q;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      wstrb0_d  = wstrb0_q;
      bvalid_d  = bvalid_q;
      if (s_axi_awvalid && awready_q) begin
         aw_full_d = 1'b1;
         waddr_d   = s_axi_awaddr[3:2];
      end
      if (s_axi_wvalid && wready_q) begin
         w_full_d = 1'b1;
         wdata_d  = s_axi_wdata[2:0];
         wstrb0_d = s_axi_wstrb[0];
      end
      if (wr_fire) begin
         bvalid_d  = 1'b1;
         aw_full_d = 1'b0;
         w_full_d  = 1'b0;
      end else if (bvalid_q && s_axi_bready) begin
         bvalid_d = 1'b0;
      end
   end

   always_comb begin
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      if (s_axi_arvalid && arready_q) begin
         rvalid_d = 1'b1;
         case (s_axi_araddr[3:2])
            2'd0:    rdata_d = AXI_DATA_WIDTH'({irq_en_q, 1'b0});
            2'd1:    rdata_d = AXI_DATA_WIDTH'({err_q, done_q, state_q == RUN});
            2'd2:    rdata_d = AXI_DATA_WIDTH'(line_cnt_q);
            default: rdata_d = AXI_DATA_WIDTH'(frame_cnt_q);
         endcase
      end else if (rvalid_q && s_axi_rready) begin
         rvalid_d = 1'b0;
      end
      arready_d = !rvalid_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start_req) state_d = RUN;
         RUN:  if (abort_req || frame_end) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      upsp_en   = (state_q == RUN);
      clr_pulse = ((state_q == IDLE) && start_req) || ((state_q == RUN) && abort_req);
      upsp_clr  = clr_pulse;
   end

   // Abort beats frame completion; hardware sets of DONE/ERR beat a same-cycle W1C.
   always_comb begin
      beat_cnt_d  = beat_cnt_q;
      line_cnt_d  = line_cnt_q;
      frame_cnt_d = frame_cnt_q;
      irq_en_d    = irq_en_q;
      done_d      = done_q;
      err_d       = err_q;
      if (clr_pulse) begin
         beat_cnt_d = '0;
         line_cnt_d = '0;
      end else if ((state_q == RUN) && hs) begin
         if (beat_last) begin
            beat_cnt_d = '0;
            line_cnt_d = line_last ? '0 : line_cnt_q + 32'd1;
         end else begin
            beat_cnt_d = beat_cnt_q + 32'd1;
         end
      end
      if (frame_end && !abort_req) frame_cnt_d = frame_cnt_q + 32'd1;
      if (ctrl_wr) irq_en_d = wdata_q[1];
      if (status_wr && wdata_q[1]) done_d = 1'b0;
      if (status_wr && wdata_q[2]) err_d = 1'b0;
      if (frame_end && !abort_req) done_d = 1'b1;
      if ((state_q == RUN) && hs && (mon_tlast != beat_last)) err_d = 1'b1;
      irq_d = done_q && irq_en_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         awready_q   <= 1'b0;
         wready_q    <= 1'b0;
         aw_full_q   <= 1'b0;
         w_full_q    <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         wstrb0_q    <= 1'b0;
         bvalid_q    <= 1'b0;
         arready_q   <= 1'b0;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
         beat_cnt_q  <= '0;
         line_cnt_q  <= '0;
         frame_cnt_q <= '0;
         irq_en_q    <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         irq_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         awready_q   <= awready_d;
         wready_q    <= wready_d;
         aw_full_q   <= aw_full_d;
         w_full_q    <= w_full_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         wstrb0_q    <= wstrb0_d;
         bvalid_q    <= bvalid_d;
         arready_q   <= arready_d;
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
         beat_cnt_q  <= beat_cnt_d;
         line_cnt_q  <= line_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         irq_en_q    <= irq_en_d;
         done_q      <= done_d;
         err_q       <= err_d;
         irq_q       <= irq_d;
      end
   end

   assign s_axi_awready    = awready_q;
   assign s_axi_wready     = wready_q;
   assign s_axi_bvalid     = bvalid_q;
   assign s_axi_bresp      = 2'b00;
   assign s_axi_arready    = arready_q;
   assign s_axi_rvalid     = rvalid_q;
   assign s_axi_rdata      = rdata_q;
   assign s_axi_rresp      = 2'b00;
   assign interrupt_updone = irq_q;

endmodule

// File: tb/tb_bcci_frame_ctrl.sv
// tb/tb_bcci_frame_ctrl.sv - scoreboard bench for bcci_frame_ctrl on a 4x2 frame
module tb_bcci_frame_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s_axi_awvalid = 1'b0, s_axi_awready;
   logic [31:0] s_axi_awaddr = '0;
   logic        s_axi_wvalid = 1'b0, s_axi_wready;
   logic [31:0] s_axi_wdata = '0;
   logic [3:0]  s_axi_wstrb = '0;
   logic        s_axi_bvalid, s_axi_bready = 1'b0;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_arvalid = 1'b0, s_axi_arready;
   logic [31:0] s_axi_araddr = '0;
   logic        s_axi_rvalid, s_axi_rready = 1'b0;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        mon_tvalid = 1'b0, mon_tready = 1'b0, mon_tlast = 1'b0;
   logic        upsp_en, upsp_clr, interrupt_updone;

   int          n_tests = 0;
   int          n_fail = 0;
   int          clr_cnt = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;
   always @(negedge clk) if (upsp_clr) clr_cnt++;

   bcci_frame_ctrl #(
      .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32),
      .DST_IMG_WIDTH(4), .DST_IMG_HEIGHT(2), .PIX_PER_BEAT(1)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
      .s_axi_wstrb(s_axi_wstrb),
      .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
      .s_axi_rresp(s_axi_rresp),
      .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
      .upsp_en(upsp_en), .upsp_clr(upsp_clr), .interrupt_updone(interrupt_updone)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Caller sits on a negedge; a valid seen with ready there completes on the next posedge.
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int w_delay, input int b_delay, input bit probe_aw,
                            output logic irq_b0, output logic irq_b1);
      int cyc = 0;
      int bv_cnt = 0;
      int aw_extra = 0;
      bit aw_hs = 0, w_hs = 0, aw_done = 0, w_done = 0;
      irq_b1 = 1'b0;
      s_axi_awaddr  = addr;
      s_axi_awvalid = 1'b1;
      while (!(aw_done && w_done) && cyc < 60) begin
         if (cyc == w_delay) begin
            s_axi_wdata  = data;
            s_axi_wstrb  = strb;
            s_axi_wvalid = 1'b1;
         end
         if (s_axi_awvalid && s_axi_awready) aw_hs = 1;
         if (s_axi_wvalid && s_axi_wready) w_hs = 1;
         @(negedge clk);
         cyc++;
         if (aw_hs) begin s_axi_awvalid = 1'b0; aw_done = 1; aw_hs = 0; end
         if (w_hs)  begin s_axi_wvalid = 1'b0; w_done = 1; w_hs = 0; end
      end
      check("wr_addr_data_hs", 32'(aw_done && w_done), 32'd1);
      cyc = 0;
      while (!s_axi_bvalid && cyc < 20) begin @(negedge clk); cyc++; end
      check("bvalid_rise", 32'(s_axi_bvalid), 32'd1);
      irq_b0 = interrupt_updone;
      if (probe_aw) begin s_axi_awaddr = 32'hC; s_axi_awvalid = 1'b1; end
      for (int i = 0; i < b_delay; i++) begin
         @(negedge clk);
         if (i == 0) irq_b1 = interrupt_updone;
         if (s_axi_bvalid) bv_cnt++;
         if (s_axi_awready) aw_extra++;
      end
      s_axi_awvalid = 1'b0;
      check("bvalid_hold", 32'(bv_cnt), 32'(b_delay));
      check("aw_blocked", 32'(aw_extra), 32'd0);
      check("bresp", 32'(s_axi_bresp), 32'd0);
      s_axi_bready = 1'b1;
      @(negedge clk);
      s_axi_bready = 1'b0;
      check("bvalid_clear", 32'(s_axi_bvalid), 32'd0);
   endtask

   task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp, input int r_delay);
      int cyc = 0;
      int rv_cnt = 0;
      bit hs = 0;
      logic [31:0] e;
      exp_q.push_back(exp);
      s_axi_araddr  = addr;
      s_axi_arvalid = 1'b1;
      while (!hs && cyc < 20) begin
         if (s_axi_arready) hs = 1;
         @(negedge clk);
         cyc++;
      end
      s_axi_arvalid = 1'b0;
      check("ar_hs", 32'(hs), 32'd1);
      cyc = 0;
      while (!s_axi_rvalid && cyc < 20) begin @(negedge clk); cyc++; end
      for (int i = 0; i < r_delay; i++) begin
         @(negedge clk);
         if (s_axi_rvalid) rv_cnt++;
      end
      check("rvalid_hold", 32'(rv_cnt), 32'(r_delay));
      check("rvalid", 32'(s_axi_rvalid), 32'd1);
      e = exp_q.pop_front();
      check($sformatf("rdata@%0h", addr), s_axi_rdata, e);
      check("rresp", 32'(s_axi_rresp), 32'd0);
      s_axi_rready = 1'b1;
      @(negedge clk);
      s_axi_rready = 1'b0;
   endtask

   // A stalled cycle with tlast high precedes beat 1; it must not be counted.
   task automatic stream(input int n, input logic [31:0] last_mask, input bit full_frame);
      int en_cnt = 0;
      for (int i = 0; i < n; i++) begin
         if (i == 1) begin
            mon_tvalid = 1'b1; mon_tready = 1'b0; mon_tlast = 1'b1;
            @(negedge clk);
         end
         mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = last_mask[i];
         if (upsp_en) en_cnt++;
         @(negedge clk);
      end
      mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
      check("en_during_beats", 32'(en_cnt), 32'(n));
      check("en_after_beats", 32'(upsp_en), full_frame ? 32'd0 : 32'd1);
   endtask

   initial begin
      logic i0, i1;
      int   c0;
      repeat (2) @(negedge clk);
      check("reset_outputs", 32'({upsp_en, upsp_clr, interrupt_updone, s_axi_awready, s_axi_wready,
                                  s_axi_bvalid, s_axi_arready, s_axi_rvalid}), 32'd0);
      check("reset_rdata", s_axi_rdata, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      axi_read(32'h4, 32'h0, 0);
      axi_read(32'hC, 32'h0, 0);

      c0 = clr_cnt;
      axi_write(32'h0, 32'h3, 4'h1, 0, 1, 0, i0, i1);
      check("t1_clr_pulse", 32'(clr_cnt - c0), 32'd1);
      check("t1_en", 32'(upsp_en), 32'd1);
      axi_read(32'h4, 32'h1, 0);
      stream(8, 32'h88, 1);
      repeat (2) @(negedge clk);
      check("t1_irq", 32'(interrupt_updone), 32'd1);
      axi_read(32'h4, 32'h2, 0);
      axi_read(32'hC, 32'h1, 0);
      axi_read(32'h0, 32'h2, 0);
      check("t1_clr_once", 32'(clr_cnt - c0), 32'd1);

      axi_write(32'h4, 32'h2, 4'h1, 0, 1, 0, i0, i1);
      check("t2_irq_at_write", 32'(i0), 32'd1);
      check("t2_irq_after", 32'(i1), 32'd0);
      axi_read(32'h4, 32'h0, 0);

      c0 = clr_cnt;
      axi_write(32'h0, 32'h1, 4'h1, 0, 1, 0, i0, i1);
      stream(5, 32'h08, 0);
      axi_read(32'h8, 32'h1, 0);
      axi_write(32'h0, 32'h4, 4'h1, 0, 1, 0, i0, i1);
      check("t3_clr_pulses", 32'(clr_cnt - c0), 32'd2);
      check("t3_en", 32'(upsp_en), 32'd0);
      axi_read(32'h4, 32'h0, 0);
      axi_read(32'h8, 32'h0, 0);
      axi_read(32'hC, 32'h1, 0);

      axi_write(32'h0, 32'h1, 4'h1, 0, 1, 0, i0, i1);
      stream(8, 32'h84, 1);
      axi_read(32'h4, 32'h6, 0);
      axi_read(32'hC, 32'h2, 0);
      axi_write(32'h4, 32'h6, 4'h1, 0, 1, 0, i0, i1);
      axi_read(32'h4, 32'h0, 0);

      axi_write(32'h0, 32'h1, 4'h0, 0, 1, 0, i0, i1);
      axi_read(32'h4, 32'h0, 0);

      axi_write(32'h0, 32'h1, 4'h1, 3, 4, 1, i0, i1);
      stream(5, 32'h08, 0);
      axi_read(32'h8, 32'h1, 3);
      axi_read(32'h4, 32'h1, 0);

      rst_n = 1'b0;
      #1;
      check("t6_async_outputs", 32'({upsp_en, upsp_clr, interrupt_updone, s_axi_awready, s_axi_wready,
                                     s_axi_bvalid, s_axi_arready, s_axi_rvalid}), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      axi_read(32'h4, 32'h0, 0);
      axi_read(32'hC, 32'h0, 0);
      axi_read(32'h8, 32'h0, 0);

      axi_write(32'h0, 32'h5, 4'h1, 0, 1, 0, i0, i1);
      axi_read(32'h4, 32'h1, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
